// File: rtl/ofmap_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ofmap_write_scheduler
// Purpose  : Arbitrates NUM_REQ output-channel producers (systolic-array
//            column drains) onto the single write port of the output
//            feature-map buffer. On start it lays out one S*S region per
//            channel after base_addr. It then grants one producer per cycle
//            and issues the registered buffer write. done pulses once every
//            channel has written exactly S*S pixels.
// Revision : 1.0 - initial release
//
// Ports
//   w_clk                  in   clock, rising edge
//   reset                  in   asynchronous active-low reset
//   start                  in   one-cycle layer start (accepted only in IDLE)
//   base_addr              in   first buffer word of channel 0
//   output_featuremapsize  in   output map side length S
//   req_valid              in   per-producer pixel valid
//   req_data               in   pixel i at [i*DATA_W +: DATA_W]
//   req_ready              out  one-hot grant (combinational)
//   buf_full               in   buffer cannot accept a write this cycle
//   wr_en/wr_addr/wr_data  out  registered buffer write port
//   busy                   out  high during INIT and RUN
//   done                   out  one-cycle pulse at layer end
//
// Configuration macro
//   OFMAP_SCHED_FIXED_PRIO_EN : when defined, the lowest eligible index wins
//                               every cycle. Otherwise round-robin is used.
// ============================================================================
module ofmap_write_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12
) (
    input  logic                      w_clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [7:0]                output_featuremapsize,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      buf_full,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [15:0]         r_region;
    logic [ADDR_W-1:0]   r_ptr [NUM_REQ];
    logic [15:0]         r_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]  r_fin;
    logic [IDX_W-1:0]    r_init_k;

    logic [15:0]         w_start_region;
    logic [ADDR_W-1:0]   w_region_a;
    logic [NUM_REQ-1:0]  w_elig;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_found;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_last;
    logic [NUM_REQ-1:0]  w_fin_next;

    // 8x8 product always fits in 16 bits.
    assign w_start_region = {8'd0, output_featuremapsize} * {8'd0, output_featuremapsize};

    // Region stride in address units; address math wraps modulo 2^ADDR_W.
    if (ADDR_W <= 16) begin : g_rgn_trunc
        assign w_region_a = r_region[ADDR_W-1:0];
    end else begin : g_rgn_ext
        assign w_region_a = {{(ADDR_W-16){1'b0}}, r_region};
    end

    assign w_elig = req_valid & ~r_fin;

`ifdef OFMAP_SCHED_FIXED_PRIO_EN
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_elig[i]) begin
                w_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] w_gidx;

    // Search begins one past the last granted channel so every channel
    // gets a turn within NUM_REQ grants.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_found && w_elig[idx]) begin
                w_grant[idx] = 1'b1;
                w_gidx       = IDX_W'(idx);
                w_found      = 1'b1;
            end
        end
    end
`endif

    assign req_ready = ((r_state == S_RUN) && !buf_full) ? w_grant : '0;
    assign w_xfer    = |req_ready;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = r_ptr[i];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
                w_sel_last = (r_cnt[i] == (r_region - 16'd1));
            end
        end
    end

    // Finished set including this cycle's transfer, so the last write and
    // the move to DONE happen on the same edge.
    assign w_fin_next = r_fin | ((w_xfer && w_sel_last) ? w_grant : '0);

    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_region <= '0;
            r_fin    <= '0;
            r_init_k <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_ptr[i] <= '0;
                r_cnt[i] <= '0;
            end
`ifndef OFMAP_SCHED_FIXED_PRIO_EN
            r_last_grant <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_region <= w_start_region;
                        r_ptr[0] <= base_addr;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            r_cnt[i] <= '0;
                        end
                        // An empty region is finished before it starts.
                        r_fin    <= {NUM_REQ{(w_start_region == 16'd0)}};
                        r_init_k <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_INIT;
                    end
                end
                S_INIT: begin
                    // One channel base per cycle keeps a single adder.
                    for (int i = 1; i < NUM_REQ; i++) begin
                        if (r_init_k == IDX_W'(i - 1)) begin
                            r_ptr[i] <= r_ptr[i-1] + w_region_a;
                        end
                    end
                    r_init_k <= r_init_k + IDX_W'(1);
                    if (r_init_k == IDX_W'(NUM_REQ - 2)) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        wr_en   <= 1'b1;
                        wr_addr <= w_sel_addr;
                        wr_data <= w_sel_data;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (w_grant[i]) begin
                                r_ptr[i] <= r_ptr[i] + 1'b1;
                                r_cnt[i] <= r_cnt[i] + 16'd1;
                            end
                        end
                        r_fin <= w_fin_next;
`ifndef OFMAP_SCHED_FIXED_PRIO_EN
                        r_last_grant <= w_gidx;
`endif
                    end
                    if (&w_fin_next) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ofmap_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofmap_write_scheduler
// Purpose  : Directed self-checking bench for ofmap_write_scheduler
//            (NUM_REQ=4, DATA_W=16, ADDR_W=12). Producer i drives pixel
//            16'hC000 | i<<8 | k, where k counts its accepted transfers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofmap_write_scheduler;

    logic        w_clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [7:0]  output_featuremapsize = '0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        buf_full = 1'b0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    int          pcnt [4];
    int          pend_ch = -1;
    int          cyc = 0;
    int          grant_q [$];
    logic [27:0] write_q [$];
    int          write_cyc_q [$];
    int          done_cnt = 0;
    int          done_cyc = -1;

    ofmap_write_scheduler #(.NUM_REQ(4), .DATA_W(16), .ADDR_W(12)) dut (
        .w_clk                 (w_clk),
        .reset                 (reset),
        .start                 (start),
        .base_addr             (base_addr),
        .output_featuremapsize (output_featuremapsize),
        .req_valid             (req_valid),
        .req_data              (req_data),
        .req_ready             (req_ready),
        .buf_full              (buf_full),
        .wr_en                 (wr_en),
        .wr_addr               (wr_addr),
        .wr_data               (wr_data),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 w_clk = ~w_clk;

    always @(posedge w_clk) cyc++;

    always_comb begin
        req_data = '0;
        for (int c = 0; c < 4; c++) begin
            req_data[c*16 +: 16] = 16'hC000 + 16'(c * 256) + 16'(pcnt[c]);
        end
    end

    // Observer: grants are seen the cycle before their edge, writes the cycle after.
    always @(negedge w_clk) begin
        if (pend_ch >= 0) begin
            pcnt[pend_ch]++;
            pend_ch = -1;
        end
        #1;
        for (int c = 0; c < 4; c++) begin
            if (req_ready[c] && req_valid[c]) begin
                grant_q.push_back(c);
                pend_ch = c;
            end
        end
        if (wr_en) begin
            write_q.push_back({wr_addr, wr_data});
            write_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic int exp_ch_full(input int n);
`ifdef OFMAP_SCHED_FIXED_PRIO_EN
        return n / 4;
`else
        return n % 4;
`endif
    endfunction

    // Channels 0,1,3 after channel 2 finished last.
    function automatic int exp_ch_rest(input int j);
`ifdef OFMAP_SCHED_FIXED_PRIO_EN
        return (j < 9) ? 0 : ((j < 18) ? 1 : 3);
`else
        return (j % 3 == 0) ? 3 : ((j % 3 == 1) ? 0 : 1);
`endif
    endfunction

    function automatic logic [27:0] exp_word(input logic [11:0] b, input int ch,
                                             input int k, input int r);
        logic [11:0] a;
        logic [15:0] d;
        a = b + 12'(ch * r + k);
        d = 16'hC000 | 16'(ch * 256) | 16'(k);
        return {a, d};
    endfunction

    task automatic clear_log();
        grant_q.delete();
        write_q.delete();
        write_cyc_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        pend_ch  = -1;
        for (int c = 0; c < 4; c++) pcnt[c] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; buf_full = 1'b0; req_valid = '0;
        repeat (2) @(negedge w_clk);
        reset = 1'b1;
        clear_log();
    endtask

    task automatic start_layer(input logic [11:0] b, input logic [7:0] s);
        @(negedge w_clk);
        base_addr = b; output_featuremapsize = s; start = 1'b1;
        @(negedge w_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int maxcyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxcyc; i++) begin
            @(negedge w_clk); #2;
            if (done_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge w_clk); #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        checks++; if (wr_addr !== 12'h0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
        checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int kc [4];
        do_reset();
        req_valid = 4'hF;
        start_layer(12'h100, 8'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy_after_start: got %b expected 1", busy); end
        #2;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rr_init_no_grant: got %h expected 0", req_ready); end
        wait_done(1, 60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_done_timeout: got %b expected 1", ok); end
        checks++; if (write_q.size() != 16) begin errors++; $display("FAIL rr_write_count: got %0d expected 16", write_q.size()); end
        checks++; if (grant_q.size() != 16) begin errors++; $display("FAIL rr_grant_count: got %0d expected 16", grant_q.size()); end
        for (int c = 0; c < 4; c++) kc[c] = 0;
        for (int n = 0; n < 16 && n < write_q.size() && n < grant_q.size(); n++) begin
            int ch;
            logic [27:0] ew;
            ch = exp_ch_full(n);
            ew = exp_word(12'h100, ch, kc[ch], 4);
            checks++; if (grant_q[n] != ch) begin errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", n, grant_q[n], ch); end
            checks++; if (write_q[n] !== ew) begin errors++; $display("FAIL rr_write[%0d]: got %h expected %h", n, write_q[n], ew); end
            kc[ch]++;
        end
        if (write_cyc_q.size() == 16) begin
            checks++; if (done_cyc != write_cyc_q[15]) begin errors++; $display("FAIL rr_done_with_last_write: got cycle %0d expected %0d", done_cyc, write_cyc_q[15]); end
            checks++; if (write_cyc_q[15] - write_cyc_q[0] != 15) begin errors++; $display("FAIL rr_throughput: got span %0d expected 15", write_cyc_q[15] - write_cyc_q[0]); end
        end
        @(negedge w_clk); #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_after_done: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rr_done_single_pulse: got %b expected 0", done); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rr_done_count: got %0d expected 1", done_cnt); end
        @(negedge w_clk);
        req_valid = '0;
    endtask

    task automatic test_single_channel();
        bit ok;
        int kc [4];
        do_reset();
        req_valid = 4'b0100;
        start_layer(12'h200, 8'd3);
        for (int i = 0; i < 40 && write_q.size() < 9; i++) begin
            @(negedge w_clk); #2;
        end
        repeat (3) @(negedge w_clk);
        #2;
        checks++; if (write_q.size() != 9) begin errors++; $display("FAIL single_ch2_writes: got %0d expected 9", write_q.size()); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL single_ch2_ready_low: got %h expected 0", req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL single_no_early_done: got %0d expected 0", done_cnt); end
        for (int j = 0; j < 9 && j < write_q.size() && j < grant_q.size(); j++) begin
            logic [27:0] ew;
            ew = exp_word(12'h200, 2, j, 9);
            checks++; if (grant_q[j] != 2) begin errors++; $display("FAIL single_grant[%0d]: got %0d expected 2", j, grant_q[j]); end
            checks++; if (write_q[j] !== ew) begin errors++; $display("FAIL single_write[%0d]: got %h expected %h", j, write_q[j], ew); end
        end
        @(negedge w_clk);
        req_valid = 4'b1111;
        wait_done(1, 80, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_done_timeout: got %b expected 1", ok); end
        checks++; if (write_q.size() != 36) begin errors++; $display("FAIL single_total_writes: got %0d expected 36", write_q.size()); end
        for (int c = 0; c < 4; c++) kc[c] = 0;
        for (int j = 0; j < 27 && 9 + j < write_q.size(); j++) begin
            int ch;
            logic [27:0] ew;
            ch = exp_ch_rest(j);
            ew = exp_word(12'h200, ch, kc[ch], 9);
            checks++; if (write_q[9+j] !== ew) begin errors++; $display("FAIL single_rest_write[%0d]: got %h expected %h", j, write_q[9+j], ew); end
            kc[ch]++;
        end
        @(negedge w_clk);
        req_valid = '0;
    endtask

    task automatic test_buf_full();
        bit ok;
        int kc [4];
        int gq0;
        int wq0;
        do_reset();
        req_valid = 4'hF;
        start_layer(12'h300, 8'd2);
        for (int i = 0; i < 40 && write_q.size() < 5; i++) begin
            @(negedge w_clk); #2;
        end
        @(negedge w_clk);
        buf_full = 1'b1;
        #2;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL full_ready_first: got %h expected 0", req_ready); end
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL full_inflight_write: got %b expected 1", wr_en); end
        gq0 = grant_q.size();
        wq0 = write_q.size();
        for (int i = 0; i < 4; i++) begin
            @(negedge w_clk); #2;
            checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL full_ready[%0d]: got %h expected 0", i, req_ready); end
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL full_wr_en[%0d]: got %b expected 0", i, wr_en); end
        end
        checks++; if (grant_q.size() != gq0) begin errors++; $display("FAIL full_no_grants: got %0d expected %0d", grant_q.size(), gq0); end
        checks++; if (write_q.size() != wq0) begin errors++; $display("FAIL full_no_writes: got %0d expected %0d", write_q.size(), wq0); end
        @(negedge w_clk);
        buf_full = 1'b0;
        wait_done(1, 60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_done_timeout: got %b expected 1", ok); end
        checks++; if (write_q.size() != 16) begin errors++; $display("FAIL full_total_writes: got %0d expected 16", write_q.size()); end
        for (int c = 0; c < 4; c++) kc[c] = 0;
        for (int n = 0; n < 16 && n < write_q.size(); n++) begin
            int ch;
            logic [27:0] ew;
            ch = exp_ch_full(n);
            ew = exp_word(12'h300, ch, kc[ch], 4);
            checks++; if (write_q[n] !== ew) begin errors++; $display("FAIL full_write[%0d]: got %h expected %h", n, write_q[n], ew); end
            kc[ch]++;
        end
        @(negedge w_clk);
        req_valid = '0;
    endtask

    task automatic test_zero_size();
        bit ok;
        int busy_cnt;
        do_reset();
        req_valid = 4'hF;
        start_layer(12'h050, 8'd0);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge w_clk);
            #2;
            if (busy === 1'b1) busy_cnt++;
        end
        checks++; if (busy_cnt != 4) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 4", busy_cnt); end
        checks++; if (write_q.size() != 0) begin errors++; $display("FAIL zero_no_writes: got %0d expected 0", write_q.size()); end
        checks++; if (grant_q.size() != 0) begin errors++; $display("FAIL zero_no_grants: got %0d expected 0", grant_q.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_pulse: got %0d expected 1", done_cnt); end
        // Back in IDLE: a fresh S=1 layer must be accepted.
        start_layer(12'h050, 8'd1);
        wait_done(2, 40, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL zero_restart_timeout: got %b expected 1", ok); end
        checks++; if (write_q.size() != 4) begin errors++; $display("FAIL s1_writes: got %0d expected 4", write_q.size()); end
        for (int n = 0; n < 4 && n < write_q.size(); n++) begin
            logic [27:0] ew;
            ew = exp_word(12'h050, n, 0, 1);
            checks++; if (write_q[n] !== ew) begin errors++; $display("FAIL s1_write[%0d]: got %h expected %h", n, write_q[n], ew); end
        end
        @(negedge w_clk);
        req_valid = '0;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int kc [4];
        do_reset();
        req_valid = 4'hF;
        start_layer(12'h100, 8'd2);
        for (int i = 0; i < 40 && write_q.size() < 7; i++) begin
            @(negedge w_clk); #2;
        end
        @(negedge w_clk);
        #3;
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL midreset_req_ready: got %h expected 0", req_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL midreset_wr_en: got %b expected 0", wr_en); end
        checks++; if (wr_addr !== 12'h0) begin errors++; $display("FAIL midreset_wr_addr: got %h expected 0", wr_addr); end
        checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL midreset_wr_data: got %h expected 0", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        @(negedge w_clk);
        reset = 1'b1;
        clear_log();
        start_layer(12'h100, 8'd2);
        wait_done(1, 60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL restart_done_timeout: got %b expected 1", ok); end
        checks++; if (write_q.size() != 16) begin errors++; $display("FAIL restart_writes: got %0d expected 16", write_q.size()); end
        for (int c = 0; c < 4; c++) kc[c] = 0;
        for (int n = 0; n < 16 && n < write_q.size(); n++) begin
            int ch;
            logic [27:0] ew;
            ch = exp_ch_full(n);
            ew = exp_word(12'h100, ch, kc[ch], 4);
            checks++; if (write_q[n] !== ew) begin errors++; $display("FAIL restart_write[%0d]: got %h expected %h", n, write_q[n], ew); end
            kc[ch]++;
        end
        @(negedge w_clk);
        req_valid = '0;
    endtask

    initial begin
        for (int c = 0; c < 4; c++) pcnt[c] = 0;
        test_reset();
        test_round_robin();
        test_single_channel();
        test_buf_full();
        test_zero_size();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
